// File: rtl/hs_ready_slice.sv
// hs_ready_slice: backward (ready-path) register slice for a valid/ready stream.
// ready_in comes straight from a flop; valid/data pass through combinationally
// and a one-entry skid register absorbs the single beat in flight when the
// downstream drops ready. Saturating transfer/stall counters aid link debug.
module hs_ready_slice #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned CNT_WD  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  input  logic               ready_out,
  input  logic               cnt_clr,
  output logic               skid_full,
  output logic [CNT_WD-1:0]  cnt_in,
  output logic [CNT_WD-1:0]  cnt_out,
  output logic [CNT_WD-1:0]  stall_cnt
);

  localparam logic [CNT_WD-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                ready_in_q, ready_in_d;
  logic [DATA_WD-1:0]  skid_q, skid_d;
  logic [CNT_WD-1:0]   cnt_in_q, cnt_in_d;
  logic [CNT_WD-1:0]   cnt_out_q, cnt_out_d;
  logic [CNT_WD-1:0]   stall_cnt_q, stall_cnt_d;

  logic                xfer_in_c;
  logic                xfer_out_c;
  logic                stall_c;

  // State, registered ready and skid payload; reset discards any held beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_PASS;
      ready_in_q <= 1'b1;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_in_q <= ready_in_d;
      skid_q     <= skid_d;
    end
  end

  // Next state: capture the in-flight beat on a downstream stall, release on ready
  always_comb begin
    state_d = state_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_PASS: begin
        if (valid_in && !ready_out) begin
          skid_d  = data_in;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready_out) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
    // ready_in is the next-state decode held in a flop, so ready_out never
    // reaches ready_in combinationally
    ready_in_d = (state_d == ST_PASS);
  end

  // Outputs: bypass in PASS, present the skid beat in HOLD
  always_comb begin
    valid_out = valid_in;
    data_out  = data_in;
    if (state_q == ST_HOLD) begin
      valid_out = 1'b1;
      data_out  = skid_q;
    end
  end

  assign ready_in  = ready_in_q;
  assign skid_full = (state_q == ST_HOLD);

  // Handshake events observed by the debug counters
  always_comb begin
    xfer_in_c  = valid_in && ready_in_q;
    xfer_out_c = valid_out && ready_out;
    stall_c    = valid_out && !ready_out;
  end

  // Counter next values: clear wins, otherwise saturating increment per event
  always_comb begin
    cnt_in_d    = cnt_in_q;
    cnt_out_d   = cnt_out_q;
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      cnt_in_d    = '0;
      cnt_out_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (xfer_in_c && (cnt_in_q != CNT_MAX)) begin
        cnt_in_d = cnt_in_q + CNT_WD'(1);
      end
      if (xfer_out_c && (cnt_out_q != CNT_MAX)) begin
        cnt_out_d = cnt_out_q + CNT_WD'(1);
      end
      if (stall_c && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_WD'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_in_q    <= '0;
      cnt_out_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_in_q    <= cnt_in_d;
      cnt_out_q   <= cnt_out_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cnt_in    = cnt_in_q;
  assign cnt_out   = cnt_out_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hs_ready_slice.sv
// Bench for hs_ready_slice: directed table, hand sequences and a randomized
// run checked against a one-entry FIFO-with-bypass reference model.
module tb_hs_ready_slice;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned CWS = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          cnt_clr;

  logic          ready_in, valid_out, skid_full;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt_in, cnt_out, stall_cnt;

  logic           s_ready_in, s_valid_out, s_skid_full;
  logic [DW-1:0]  s_data_out;
  logic [CWS-1:0] s_cnt_in, s_cnt_out, s_stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hs_ready_slice #(.DATA_WD(DW), .CNT_WD(CW)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .ready_out(ready_out), .cnt_clr(cnt_clr), .skid_full(skid_full),
    .cnt_in(cnt_in), .cnt_out(cnt_out), .stall_cnt(stall_cnt)
  );

  hs_ready_slice #(.DATA_WD(DW), .CNT_WD(CWS)) dut_s (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .data_in(data_in),
    .ready_in(s_ready_in), .valid_out(s_valid_out), .data_out(s_data_out),
    .ready_out(ready_out), .cnt_clr(cnt_clr), .skid_full(s_skid_full),
    .cnt_in(s_cnt_in), .cnt_out(s_cnt_out), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          rout;
    logic          e_vo;
    logic [DW-1:0] e_do;
    logic          e_rin;
    logic          e_skid;
    int            e_ci;
    int            e_co;
    int            e_st;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1'b1;
  endtask

  // Reference model state: held beats awaiting delivery plus counters
  logic [DW-1:0] mq[$];
  int m_ci, m_co, m_st;

  int unsigned pay;
  int unsigned exp_deliv;
  logic          prev_stall;
  logic [DW-1:0] prev_do;
  logic          accepted;

  initial begin
    rstn = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0; cnt_clr = 1'b0;

    // Reset values
    do_reset(3);
    rstn = 1'b0;
    data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_ready_in", 64'(ready_in), 64'(1'b1));
    chk("rst_valid_out", 64'(valid_out), 64'(1'b0));
    chk("rst_data_out", 64'(data_out), 64'(32'hDEAD_BEEF));
    chk("rst_skid_full", 64'(skid_full), 64'(1'b0));
    chk("rst_cnt_in", 64'(cnt_in), 64'd0);
    chk("rst_cnt_out", 64'(cnt_out), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();

    // Streaming 1..8 with ready held high
    do_reset(2);
    for (int i = 1; i <= 8; i++) begin
      valid_in = 1'b1; data_in = DW'(i); ready_out = 1'b1;
      @(negedge clk);
      chk("stream_valid_out", 64'(valid_out), 64'(1'b1));
      chk("stream_data_out", 64'(data_out), 64'(i));
      chk("stream_ready_in", 64'(ready_in), 64'(1'b1));
      tick();
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("stream_cnt_in", 64'(cnt_in), 64'd8);
    chk("stream_cnt_out", 64'(cnt_out), 64'd8);
    chk("stream_stall", 64'(stall_cnt), 64'd0);
    tick();

    // Backpressure capture table
    tbl[0] = '{1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1'b0, 1'b1, 1, 0, 1};
    tbl[2] = '{1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1'b0, 1'b1, 1, 0, 2};
    tbl[3] = '{1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1'b0, 1'b1, 1, 0, 3};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hA5, 1'b0, 1'b1, 1, 0, 4};
    tbl[5] = '{1'b0, 32'h3C, 1'b1, 1'b0, 32'h3C, 1'b1, 1'b0, 1, 1, 4};
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      valid_in = tbl[i].vin; data_in = tbl[i].din; ready_out = tbl[i].rout;
      @(negedge clk);
      chk($sformatf("bp%0d_valid_out", i), 64'(valid_out), 64'(tbl[i].e_vo));
      chk($sformatf("bp%0d_data_out", i), 64'(data_out), 64'(tbl[i].e_do));
      chk($sformatf("bp%0d_ready_in", i), 64'(ready_in), 64'(tbl[i].e_rin));
      chk($sformatf("bp%0d_skid_full", i), 64'(skid_full), 64'(tbl[i].e_skid));
      chk($sformatf("bp%0d_cnt_in", i), 64'(cnt_in), 64'(tbl[i].e_ci));
      chk($sformatf("bp%0d_cnt_out", i), 64'(cnt_out), 64'(tbl[i].e_co));
      chk($sformatf("bp%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].e_st));
      tick();
    end

    // Saturation (4-bit instance) and clear with a concurrent transfer
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1; data_in = DW'(32'h100 + i); ready_out = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("sat_cnt_out4", 64'(s_cnt_out), 64'd15);
    chk("sat_cnt_in4", 64'(s_cnt_in), 64'd15);
    chk("sat_cnt_out16", 64'(cnt_out), 64'd20);
    tick();
    ready_out = 1'b0; valid_in = 1'b1; data_in = 32'h77;
    tick();
    valid_in = 1'b0; ready_out = 1'b1; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt_in", 64'(cnt_in), 64'd0);
    chk("clr_cnt_out", 64'(cnt_out), 64'd0);
    chk("clr_stall", 64'(stall_cnt), 64'd0);
    chk("clr_cnt_out4", 64'(s_cnt_out), 64'd0);
    chk("clr_stall4", 64'(s_stall_cnt), 64'd0);
    tick();

    // Reset mid-HOLD discards the skid beat
    do_reset(2);
    valid_in = 1'b1; data_in = 32'h55; ready_out = 1'b0;
    tick();
    valid_in = 1'b0; data_in = 32'h0;
    @(negedge clk);
    chk("mh_skid_full", 64'(skid_full), 64'(1'b1));
    chk("mh_data_out", 64'(data_out), 64'(32'h55));
    rstn = 1'b0;
    tick();
    rstn = 1'b1; ready_out = 1'b1;
    @(negedge clk);
    chk("mh_ready_in", 64'(ready_in), 64'(1'b1));
    chk("mh_skid_after", 64'(skid_full), 64'(1'b0));
    chk("mh_valid_out", 64'(valid_out), 64'(1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mh_never_delivered", 64'(valid_out), 64'(1'b0));
      tick();
    end
    chk("mh_cnt_out", 64'(cnt_out), 64'd0);

    // Random throttling against the reference model
    do_reset(2);
    mq.delete();
    m_ci = 0; m_co = 0; m_st = 0;
    pay = 32'h1000; exp_deliv = 32'h1000;
    prev_stall = 1'b0; prev_do = '0;
    accepted = 1'b1;
    valid_in = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic          e_rin, e_vo, acc, del;
      logic [DW-1:0] e_do;
      if (!valid_in || accepted) begin
        valid_in = ($urandom_range(0, 99) < 65);
        data_in  = DW'(pay);
      end
      ready_out = ($urandom_range(0, 99) < 55);
      @(negedge clk);
      e_rin = (mq.size() == 0);
      e_vo  = (mq.size() != 0) ? 1'b1 : valid_in;
      e_do  = (mq.size() != 0) ? mq[0] : data_in;
      chk("rnd_ready_in", 64'(ready_in), 64'(e_rin));
      chk("rnd_valid_out", 64'(valid_out), 64'(e_vo));
      if (e_vo) chk("rnd_data_out", 64'(data_out), 64'(e_do));
      chk("rnd_skid_full", 64'(skid_full), 64'(mq.size() != 0));
      chk("rnd_cnt_in", 64'(cnt_in), 64'(m_ci));
      chk("rnd_cnt_out", 64'(cnt_out), 64'(m_co));
      chk("rnd_stall", 64'(stall_cnt), 64'(m_st));
      chk("rnd_inflight", 64'(int'(cnt_in) - int'(cnt_out)), 64'(skid_full));
      if (prev_stall) chk("rnd_stable", 64'(data_out), 64'(prev_do));
      if (valid_out && ready_out) begin
        chk("rnd_order", 64'(data_out), 64'(exp_deliv));
        exp_deliv++;
      end
      prev_stall = valid_out && !ready_out;
      prev_do    = data_out;
      // Model update at the edge
      acc = e_rin && valid_in;
      del = e_vo && ready_out;
      if (del && mq.size() != 0) void'(mq.pop_front());
      if (acc && !del) mq.push_back(data_in);
      if (acc) m_ci = (m_ci < 65535) ? m_ci + 1 : m_ci;
      if (del) m_co = (m_co < 65535) ? m_co + 1 : m_co;
      if (e_vo && !ready_out) m_st = (m_st < 65535) ? m_st + 1 : m_st;
      accepted = acc;
      if (acc) pay++;
      tick();
    end
    chk("rnd_total_delivered", 64'(exp_deliv + 32'(mq.size())), 64'(pay));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_ready_slice.md
# hs_ready_slice

Backward-direction register slice for the valid/ready stream interface. It registers the ready path, so there is no combinational path from `ready_out` to `ready_in`. The forward valid/data path stays combinational, with a one-entry skid register. It is the companion to the forward (valid/data-registered) skid buffer: chaining the two gives full timing isolation in both directions. It also keeps saturating transfer and stall counters for link debug.

## Interface
- `DATA_WD`, 32, payload width in bits
- `CNT_WD`, 16, width of each statistics counter
- `clk`  in  1  single clock; all state updates on rising edge
- `rstn`  in  1  reset, synchronous, active-low; sampled only on rising edge of `clk`
- `valid_in`  in  1  upstream valid
- `data_in`  in  DATA_WD  upstream payload
- `ready_in`  out  1  upstream ready; driven directly from a flop
- `valid_out`  out  1  downstream valid
- `data_out`  out  DATA_WD  downstream payload
- `ready_out`  in  1  downstream ready
- `cnt_clr`  in  1  synchronous clear of all counters
- `skid_full`  out  1  skid register holds a beat (state HOLD)
- `cnt_in`  out  CNT_WD  accepted beats (`valid_in && ready_in`)
- `cnt_out`  out  CNT_WD  delivered beats (`valid_out && ready_out`)
- `stall_cnt`  out  CNT_WD  cycles with `valid_out && !ready_out`

## Operation
- Two states: PASS (skid empty) and HOLD (skid occupied). `ready_in` is the registered value of (next state == PASS). `skid_full` is (state == HOLD).
- **PASS**
  - `ready_in=1`.
  - `valid_out=valid_in` and `data_out=data_in`, both combinational.
  - If `valid_in && !ready_out`: capture `data_in` into skid, next state HOLD.
  - Otherwise stay in PASS.
- **HOLD**
  - `ready_in=0`.
  - `valid_out=1` and `data_out=skid`.
  - `valid_in`/`data_in` are ignored and no input transfer occurs.
  - If `ready_out`: the skid beat is delivered, next state PASS.
  - Otherwise stay in HOLD, and the skid value stays stable.
- **Protocol guarantees:**
  - `data_out` stays stable while `valid_out && !ready_out`.
  - No beat is lost or duplicated.
  - Order is preserved.
- **Upstream obligation:** once asserted, `valid_in` and `data_in` stay stable until accepted.
- **Counters**
  - Each counter increments by 1 on its event and saturates at 2^CNT_WD-1.
  - `cnt_clr` has priority over increment: counters read 0 the cycle after a clear, and events in the clear cycle are not counted.
  - Counters are independent of the state machine.
- **Reset** (while `rstn` is low at an edge):
  - State PASS, `ready_in=1`, skid data 0.
  - `skid_full=0`, all counters 0.
  - With `valid_in=0`, `valid_out=0` and `data_out=data_in`.
- **Reset mid-HOLD:** the skid beat is discarded, and the state is PASS on the next cycle.
- **Invariant (no saturation, no clear):** `cnt_in - cnt_out` is 0 in PASS and 1 in HOLD.

## Timing
- **Forward latency:** 0 cycles in PASS. A beat held in skid is delivered in the first cycle `ready_out=1`.
- **Ready latency:** a `ready_out` drop is reflected in `ready_in` one cycle later. The single in-flight beat is absorbed by skid.
- **HOLD to PASS:** in the cycle `ready_out=1` in HOLD, the skid beat transfers and `ready_in` is still 0. `ready_in=1` the next cycle. There is a one-cycle input bubble per HOLD exit.
- **Throughput:** 1 beat/cycle while `ready_out` stays high.
- **Combinational paths:**
  - Present: `valid_in` to `valid_out`, `data_in` to `data_out`.
  - Absent: `ready_out` to `ready_in`.
- **Counter update:** counters update at the edge following the event. Outputs are registered.

## Test plan
- **Reset:** hold `rstn=0` for 3 cycles with `valid_in=0`. Expect `ready_in=1`, `valid_out=0`, `skid_full=0`, all counters 0.
- **Streaming:** `ready_out=1`; send 0x1..0x8 back-to-back. Expect `data_out` to equal `data_in` in the same cycle, no bubbles, and `cnt_in=cnt_out=8`.
- **Backpressure capture:**
  - Stimulus: drive 0xA5 with `ready_out=0` for 4 cycles, then `ready_out=1`.
  - Skid: captures 0xA5; `skid_full=1`, `ready_in=0` from the next cycle.
  - Delivery: `valid_out=1`, `data_out=0xA5` until `ready_out` rises, then one bubble before `ready_in=1`.
  - Stall count: `stall_cnt=4` (3 cycles in HOLD plus the capture cycle).
- **Random throttling:** random `valid_in`/`ready_out` for 10k cycles with an incrementing payload. Check:
  - output sequence is exact;
  - `data_out` is stable under stall;
  - `cnt_in - cnt_out` equals `skid_full`.
- **Saturation and clear:** with `CNT_WD=4`, deliver 20 beats. Expect `cnt_out=15`. Then pulse `cnt_clr` in the same cycle as a transfer; expect all counters 0 next cycle.
- **Reset mid-HOLD:** in HOLD with skid=0x55, assert `rstn=0` for 1 cycle. Expect PASS, `skid_full=0`, `ready_in=1`, and 0x55 never delivered.
